// File: rtl/w0rm_writeback_arbiter.sv
// Register-file write-port arbiter: per-source FIFOs for ALU and load results,
// MEM-first priority with a starvation guard that forces an ALU grant.

module w0rm_wb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  ready,
    output logic                  not_empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

    logic [ENT_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Ready depends only on the registered count, so valid never feeds ready.
    assign ready     = (count < CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign {head_addr, head_data} = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is tracked
    // by count alone, and leaving it reset-free lets it map to plain memory.
    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr] <= {push_addr, push_data};
    end
endmodule

module w0rm_writeback_arbiter #(
    parameter  int DATA_WIDTH    = 32,
    parameter  int NUM_REGISTERS = 16,
    parameter  int FIFO_DEPTH    = 2,
    parameter  int STARVE_LIMIT  = 4,
    localparam int REG_ADDR_BITS = $clog2(NUM_REGISTERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_ADDR_BITS-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REG_ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     wr_enable,
    output logic [REG_ADDR_BITS-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     busy
);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                     alu_push, mem_push;
    logic                     alu_not_empty, mem_not_empty;
    logic [REG_ADDR_BITS-1:0] alu_head_addr, mem_head_addr;
    logic [DATA_WIDTH-1:0]    alu_head_data, mem_head_data;
    logic                     grant_alu, grant_mem;
    logic [STARVE_W-1:0]      starve_cnt;

    assign alu_push = alu_valid && alu_ready;
    assign mem_push = mem_valid && mem_ready;

    w0rm_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (alu_push),
        .push_addr (alu_addr),
        .push_data (alu_data),
        .pop       (grant_alu),
        .ready     (alu_ready),
        .not_empty (alu_not_empty),
        .head_addr (alu_head_addr),
        .head_data (alu_head_data)
    );

    w0rm_wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_BITS),
        .DEPTH      (FIFO_DEPTH)
    ) u_mem_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_push),
        .push_addr (mem_addr),
        .push_data (mem_data),
        .pop       (grant_mem),
        .ready     (mem_ready),
        .not_empty (mem_not_empty),
        .head_addr (mem_head_addr),
        .head_data (mem_head_data)
    );

    // Loads win by default; a waiting ALU result is forced through once it
    // has watched STARVE_LIMIT consecutive MEM grants.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_not_empty && mem_not_empty) begin
            if (starve_cnt == STARVE_MAX) grant_alu = 1'b1;
            else                          grant_mem = 1'b1;
        end else if (alu_not_empty) begin
            grant_alu = 1'b1;
        end else if (mem_not_empty) begin
            grant_mem = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_enable  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            starve_cnt <= '0;
        end else begin
            wr_enable <= grant_alu || grant_mem;
            if (grant_alu) begin
                wr_addr <= alu_head_addr;
                wr_data <= alu_head_data;
            end else if (grant_mem) begin
                wr_addr <= mem_head_addr;
                wr_data <= mem_head_data;
            end

            if (grant_alu || !alu_not_empty) begin
                starve_cnt <= '0;
            end else if (grant_mem && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

    assign busy = alu_not_empty || mem_not_empty || wr_enable;
endmodule

// File: tb/tb_w0rm_writeback_arbiter.sv
// Directed scoreboard bench for w0rm_writeback_arbiter: expected writes are
// queued at stimulus time and a negedge monitor matches them on the write port.

module tb_w0rm_writeback_arbiter;
    logic        clk;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wr_enable;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_list [7];

    w0rm_writeback_arbiter #(
        .DATA_WIDTH    (32),
        .NUM_REGISTERS (16),
        .FIFO_DEPTH    (2),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_write(input logic [3:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write-port strobe must match the queue head.
    always @(negedge clk) begin
        if (wr_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write (t=%0t)",
                         wr_addr, wr_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected completion by 20000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        mem_list  = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h1, 32'h2, 32'h3};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wr_enable", 32'(wr_enable), 32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_wr_data",   wr_data,        32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);

        // Single ALU push: write appears only after the following edge
        step();
        expect_write(4'd3, 32'h11);
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        check("t1_no_bypass", 32'(wr_enable), 32'd0);
        check("t1_busy_queued", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_write_strobe", 32'(wr_enable), 32'd1);
        @(negedge clk);
        check("t1_strobe_drop", 32'(wr_enable), 32'd0);
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Simultaneous pushes: MEM first, ALU immediately after
        step();
        expect_write(4'd2, 32'hB);
        expect_write(4'd1, 32'hA);
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'hB;
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        check("t2_idle_first", 32'(wr_enable), 32'd0);
        @(negedge clk);
        check("t2_mem_cycle", 32'(wr_enable), 32'd1);
        @(negedge clk);
        check("t2_alu_cycle", 32'(wr_enable), 32'd1);
        @(negedge clk);
        check("t2_done", 32'(wr_enable), 32'd0);

        // MEM stream with one waiting ALU entry: 4 MEM writes, ALU, then MEM
        // resumes; the ALU grant stalls MEM long enough to fill its FIFO.
        step();
        for (int i = 0; i < 4; i++) expect_write(4'd5, mem_list[i]);
        expect_write(4'd7, 32'hA1);
        for (int i = 4; i < 7; i++) expect_write(4'd5, mem_list[i]);
        begin
            int  mi;
            logic acc_alu, acc_mem;
            mi = 0;
            alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'hA1;
            mem_valid = 1'b1; mem_addr = 4'd5; mem_data = mem_list[0];
            for (int c = 0; c <= 10; c++) begin
                @(negedge clk);
                if (c >= 2 && c <= 9) check($sformatf("t3_strobe_c%0d", c), 32'(wr_enable), 32'd1);
                if (c == 5) begin
                    check("t3_starve_at_limit", 32'(dut.starve_cnt), 32'd4);
                    check("t3_mem_ready_pre", 32'(mem_ready), 32'd1);
                end
                if (c == 6) begin
                    check("t3_mem_full_ready", 32'(mem_ready), 32'd0);
                    check("t3_starve_cleared", 32'(dut.starve_cnt), 32'd0);
                end
                if (c == 7) check("t3_mem_ready_back", 32'(mem_ready), 32'd1);
                if (c == 10) check("t3_drained", 32'(wr_enable), 32'd0);
                acc_alu = alu_valid && alu_ready;
                acc_mem = mem_valid && mem_ready;
                step();
                if (acc_alu) alu_valid = 1'b0;
                if (acc_mem) begin
                    mi++;
                    if (mi == 7) mem_valid = 1'b0;
                    else         mem_data = mem_list[mi];
                end
            end
            check("t3_all_mem_accepted", 32'(mi), 32'd7);
        end

        // Reset mid-operation: only writes registered before reset appear
        for (int i = 0; i < 3; i++) expect_write(4'd9, 32'h300 + 32'(i));
        for (int k = 0; k <= 4; k++) begin
            alu_valid = 1'b1; alu_addr = 4'd8; alu_data = 32'h200 + 32'(k);
            mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h300 + 32'(k);
            if (k == 4) reset = 1'b1;
            @(negedge clk);
            if (k == 3) check("t5_alu_full", 32'(alu_ready), 32'd0);
            if (k == 4) begin
                check("t5_pre_reset_strobe", 32'(wr_enable), 32'd1);
                check("t5_pre_reset_busy", 32'(busy), 32'd1);
            end
            step();
        end
        reset     = 1'b0;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        check("t5_wr_enable", 32'(wr_enable), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_alu_ready", 32'(alu_ready), 32'd1);
        check("t5_mem_ready", 32'(mem_ready), 32'd1);
        check("t5_wr_addr", 32'(wr_addr), 32'd0);
        repeat (6) @(negedge clk);
        check("t5_still_idle", 32'(busy), 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/w0rm_writeback_arbiter.md
Name: w0rm_writeback_arbiter

Overview:
- Shares the single register-file write port between the ALU result path and the memory (load) result path.
- Each source feeds a small FIFO; a fixed-priority arbiter with a starvation guard drains one entry per cycle into registered write-port outputs.
- Sits between execute/memory stages and the register file write port (write addr / enable / data).

Parameters:
- DATA_WIDTH, 32, width of write data.
- NUM_REGISTERS, 16, register count; REG_ADDR_BITS = ceil(log2(NUM_REGISTERS)).
- FIFO_DEPTH, 2, entries per source FIFO; power of two, >= 2.
- STARVE_LIMIT, 4, consecutive MEM grants tolerated while ALU is waiting; >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU FIFO can accept.
- alu_addr  in  REG_ADDR_BITS  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  MEM FIFO can accept.
- mem_addr  in  REG_ADDR_BITS  load destination register.
- mem_data  in  DATA_WIDTH  load data.
- wr_enable  out  1  register-file write strobe.
- wr_addr  out  REG_ADDR_BITS  write address.
- wr_data  out  DATA_WIDTH  write data.
- busy  out  1  any FIFO non-empty or wr_enable high.

Behaviour:
- Reset: FIFO pointers and counts = 0; starvation counter = 0; wr_enable = 0, wr_addr = 0, wr_data = 0; alu_ready = mem_ready = 1 in the cycle after reset deasserts; busy = 0. Reset mid-operation discards all queued entries.
- Handshake: a transfer occurs on an edge where valid && ready. ready = (count < FIFO_DEPTH), taken from registered count only; no combinational path from valid to ready. A full FIFO deasserts ready, and an offer made while full is not accepted.
- Pop and push in the same cycle on a full FIFO: ready stays 0 that cycle (count-based). Count is unchanged when a push and a pop occur together.
- Arbitration each cycle, on FIFO heads:
  - Neither FIFO non-empty: no grant; wr_enable <= 0; wr_addr/wr_data hold.
  - Only one non-empty: grant that one.
  - Both non-empty: grant ALU if starve_cnt == STARVE_LIMIT, else grant MEM.
- Grant pops the head and registers it: wr_enable <= 1, wr_addr/wr_data <= head at the same edge.
- Latency: an entry pushed into an empty FIFO at edge N, with no competing grant, produces wr_enable = 1 after edge N+1. There is no bypass from inputs.
- starve_cnt (width for 0..STARVE_LIMIT):
  - Cleared when ALU is granted or the ALU FIFO is empty.
  - Incremented when MEM is granted while the ALU FIFO is non-empty.
  - Saturates at STARVE_LIMIT.
- Throughput: at most one write per cycle; sustained total input above one per cycle backpressures via ready.
- Ordering: FIFO order is preserved within a source. There is no ordering guarantee between sources; upstream hazard logic ensures the two sources never hold outstanding writes to the same register.
- FIFO pointers wrap modulo FIFO_DEPTH.
- busy is combinational from registered state.

Test Plan:
- Reset then single ALU push (addr 3, data 0x11) at edge N -> wr_enable=1, wr_addr=3, wr_data=0x11 after edge N+1 only; busy low again one cycle later.
- Simultaneous ALU (addr 1, 0xA) and MEM (addr 2, 0xB) pushes -> MEM write on first output cycle, ALU write on the next; no cycle lost.
- Continuous MEM stream every cycle plus one ALU entry, STARVE_LIMIT=4 -> exactly 4 MEM writes, then the ALU write, then MEM resumes; starve_cnt returns to 0.
- Fill MEM FIFO (2 pushes, output stalled by ALU starvation grant), hold mem_valid with a third entry -> mem_ready=0 and the entry is not accepted until a pop; all three eventually written in order 0x1, 0x2, 0x3.
- Assert reset with both FIFOs full and wr_enable high -> next cycle wr_enable=0, busy=0, both ready=1; the discarded entries never appear on the write port.
- Random valid patterns, 10k cycles, against a reference model -> every accepted entry written exactly once, in per-source order, never two writes in one cycle.
